mod_exp_ctrl: RTL

Sequencer for the Montgomery multiply/square step unit in the modular-exponentiation datapath. Runs left-to-right square-and-multiply over a latched exponent: for each exponent bit it launches one step (accumulator squared, then multiplied by the base when the bit is 1), waits for the step's completion pulse and captures the result. Sits between the host/register interface and the step unit, owning the accumulator, base and exponent registers.

---
 rtl/mod_exp_pkg.sv | 17 +
 rtl/mod_exp_ctrl_if.sv | 29 ++
 rtl/mod_exp_ctrl_exp_bit_cursor.sv | 53 +++++
 rtl/mod_exp_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
package mod_exp_pkg;

    localparam int DEF_WIDTH      = 256;
    localparam int DEF_IDX_W      = 9;
    localparam int MM_IDLE_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LOAD,
        ST_RUN,
        ST_DROP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Host-side request/response bundle of the modular-exponentiation sequencer.
interface mod_exp_ctrl_if
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
);

    logic             start;
    logic [WIDTH-1:0] exponent;
    logic [IDX_W-1:0] exp_len;
    logic [WIDTH-1:0] base_mont;
    logic [WIDTH-1:0] one_mont;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, exponent, exp_len, base_mont, one_mont,
        input  busy, done, err, result
    );

    modport slave (
        input  start, exponent, exp_len, base_mont, one_mont,
        output busy, done, err, result
    );

endinterface

// File: rtl/mod_exp_ctrl_exp_bit_cursor.sv
// Exponent register plus bit index; walks from the top processed bit down to bit 0.
// The current bit is registered so it stays stable through the low cycle before each step.
module exp_bit_cursor
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] exp_i,
    input  logic [IDX_W-1:0] len_i,
    output logic             bit_o,
    output logic             at_zero_o
);

    logic [WIDTH-1:0] exp_q, exp_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bit_q, bit_d;

    // An index beyond the vector (len 0 or len > WIDTH) shifts the mask out and reads as 0.
    always_comb begin
        exp_d = exp_q;
        idx_d = idx_q;
        bit_d = bit_q;
        if (load_i) begin
            exp_d = exp_i;
            idx_d = len_i - IDX_W'(1);
            bit_d = |(exp_i & (WIDTH'(1) << idx_d));
        end else if (dec_i && (idx_q != '0)) begin
            idx_d = idx_q - IDX_W'(1);
            bit_d = |(exp_q & (WIDTH'(1) << idx_d));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            idx_q <= '0;
            bit_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            idx_q <= idx_d;
            bit_q <= bit_d;
        end
    end

    assign bit_o     = bit_q;
    assign at_zero_o = (idx_q == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving the Montgomery step unit.
// Build option MODEXP_SKIP_LEADING_ZEROS_EN adds SCAN, which skips leading exponent zeros.
//
// state | meaning
// IDLE  | waiting for start; latches operands
// SCAN  | searching for the leading one, one bit per cycle (option only)
// LOAD  | step unit disabled, samples the accumulator
// RUN   | step unit enabled on the current bit, waiting for mm_endflag
// DROP  | step unit disabled between steps, reloads from the new accumulator
// DONE  | publish accumulator as result, pulse done
module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    mod_exp_ctrl_if.slave    host,
    output logic             mm_enable_o,
    output logic             mm_pow_bit_o,
    output logic [WIDTH-1:0] mm_multiplicand_o,
    output logic [WIDTH-1:0] mm_indata_o,
    input  logic             mm_endflag_i,
    input  logic [WIDTH-1:0] mm_result_i
);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             mm_en_q;
    logic             last_q;
    logic [3:0]       idle_cnt_q;

    logic cur_load;
    logic cur_dec;
    logic cur_bit;
    logic cur_at_zero;
    logic len_bad;
    logic len_zero;

    assign len_bad  = (host.exp_len > IDX_W'(WIDTH));
    assign len_zero = (host.exp_len == '0);

    exp_bit_cursor #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_cursor (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cur_load),
        .dec_i     (cur_dec),
        .exp_i     (host.exponent),
        .len_i     (host.exp_len),
        .bit_o     (cur_bit),
        .at_zero_o (cur_at_zero)
    );

    // The index moves when a step completes, not in DROP, so the next bit is
    // already on mm_pow_bit_o during the low cycle that precedes its step.
    always_comb begin
        cur_load = 1'b0;
        cur_dec  = 1'b0;
        case (state_q)
            ST_IDLE: cur_load = host.start;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            ST_SCAN: cur_dec  = ~cur_at_zero;
`endif
            ST_RUN:  cur_dec  = mm_endflag_i & ~cur_at_zero;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            base_q     <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mm_en_q    <= 1'b0;
            last_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (host.start) begin
                        base_q <= host.base_mont;
                        acc_q  <= host.one_mont;
                        busy_q <= 1'b1;
                        err_q  <= len_bad;
                        if (len_bad || len_zero) begin
                            state_q <= ST_DONE;
                        end else begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                            state_q <= ST_SCAN;
`else
                            state_q <= ST_LOAD;
`endif
                        end
                    end
                end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                ST_SCAN: begin
                    // The leading one's square-and-multiply from one_mont is just base.
                    if (cur_bit) begin
                        acc_q   <= base_q;
                        state_q <= cur_at_zero ? ST_DONE : ST_LOAD;
                    end else if (cur_at_zero) begin
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_LOAD: begin
                    mm_en_q <= 1'b1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (mm_endflag_i) begin
                        acc_q      <= mm_result_i;
                        mm_en_q    <= 1'b0;
                        last_q     <= cur_at_zero;
                        idle_cnt_q <= 4'(MM_IDLE_CYCLES - 1);
                        state_q    <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (idle_cnt_q != '0) begin
                        idle_cnt_q <= idle_cnt_q - 4'd1;
                    end else if (last_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        mm_en_q <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    result_q <= acc_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign host.busy         = busy_q;
    assign host.done         = done_q;
    assign host.err          = err_q;
    assign host.result       = result_q;
    assign mm_enable_o       = mm_en_q;
    assign mm_pow_bit_o      = cur_bit;
    assign mm_multiplicand_o = acc_q;
    assign mm_indata_o       = base_q;

endmodule
